// File: rtl/count_bcd_display_if.sv
// Valid/ready handshake carrying the 8-bit binary count into the BCD display block.
interface count_bcd_display_if;
  logic [7:0] value;
  logic       valid;
  logic       ready;

  modport master (output value, output valid, input ready);
  modport slave  (input value, input valid, output ready);
endinterface

// File: rtl/count_bcd_display.sv
// Binary-to-BCD converter (iterative double-dabble, 8 shifts) driving a
// time-multiplexed three-digit 7-segment display from the latched result.
module count_bcd_display #(
  parameter int unsigned SCAN_DIV     = 1024,
  parameter bit          COMMON_ANODE = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  count_bcd_display_if.slave        bus,
  input  logic                      blank_zeros,
  output logic [11:0]               bcd,
  output logic                      bcd_valid,
  output logic [6:0]                seg,
  output logic [2:0]                dig_en
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [11:0] scratch_q, scratch_d;
  logic [2:0]  iter_q, iter_d;
  logic [11:0] bcd_q, bcd_d;
  logic [11:0] adj;
  logic [15:0] presc_q, presc_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  nib;
  logic        blank;
  logic [6:0]  seg_raw;
  logic [2:0]  dig_raw;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    bcd_d     = bcd_q;
    adj       = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          shreg_d   = bus.value;
          scratch_d = '0;
          iter_d    = '0;
          state_d   = CONV;
        end
      end
      CONV: begin
        // Nibble corrections are applied before the shift, each confined to its own nibble.
        {scratch_d, shreg_d} = {adj, shreg_q} << 1;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          bcd_d   = scratch_d;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q + 16'd1;
    idx_d   = idx_q;
    if (presc_q == SCAN_LAST) begin
      presc_d = '0;
      idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  always_comb begin
    nib     = '0;
    blank   = 1'b0;
    dig_raw = '0;
    case (idx_q)
      2'd0: begin
        nib     = bcd_q[3:0];
        dig_raw = 3'b001;
      end
      2'd1: begin
        nib     = bcd_q[7:4];
        dig_raw = 3'b010;
        blank   = blank_zeros && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        nib     = bcd_q[11:8];
        dig_raw = 3'b100;
        blank   = blank_zeros && (bcd_q[11:8] == 4'd0);
      end
      default: ;
    endcase
    seg_raw = blank ? 7'h00 : seg7(nib);
    seg     = COMMON_ANODE ? ~seg_raw : seg_raw;
    dig_en  = COMMON_ANODE ? ~dig_raw : dig_raw;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      bcd_q     <= '0;
      presc_q   <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      iter_q    <= iter_d;
      bcd_q     <= bcd_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bcd_valid = (state_q == DONE);
  assign bcd       = bcd_q;

endmodule

// File: doc/count_bcd_display.md
# count_bcd_display

Consumer side of the 8-bit up/down counter: accepts a binary count over a valid/ready handshake and converts it to three BCD digits with an iterative double-dabble engine (8 shift cycles). It then drives a time-multiplexed three-digit 7-segment display from the latched result. It sits between the counter's 8-bit output and the `uo_out` pins of the tile top.

## Interface

Parameters:

- `SCAN_DIV`, default 1024: clock cycles each digit stays selected. Legal range is 1..65535.
- `COMMON_ANODE`, default 0: when 1, `seg` and `dig_en` are inverted (active-low).

Ports:

- `clk`  in  1: single clock; everything is synchronous to its rising edge.
- `rst_n`  in  1: reset, synchronous and active-low, sampled at the `clk` rising edge.
- `value`  in  8: unsigned binary count to convert.
- `valid`  in  1: `value` is offered.
- `ready`  out  1: block can accept. A transfer occurs on an edge where `valid` and `ready` are both 1.
- `blank_zeros`  in  1: enables leading-zero blanking.
- `bcd`  out  12: latched result. Hundreds in [11:8], tens in [7:4], ones in [3:0].
- `bcd_valid`  out  1: one-cycle pulse when `bcd` has just been updated.
- `seg`  out  7: segments, bit0 = a through bit6 = g; 1 = lit (for `COMMON_ANODE`=0).
- `dig_en`  out  3: one-hot digit enable. bit0 = ones, bit1 = tens, bit2 = hundreds.

## Operation

Conversion FSM, states IDLE, CONV, DONE:

- `ready` = (state == IDLE). `bcd_valid` = (state == DONE).
- IDLE: on `valid`&`ready`, latch `value` into a shift register, clear the 12-bit scratch and the 3-bit iteration counter, and go to CONV.
- CONV: each cycle:
  - add 3 to every scratch nibble that is ≥5;
  - shift {scratch, shreg} left by 1;
  - increment the iteration counter.
- On the 8th shift edge: load `bcd` with the final scratch value and go to DONE.
- DONE: lasts one cycle, then returns to IDLE.
- `valid` is ignored outside IDLE. A `value` change during CONV has no effect on the result.
- Width rules:
  - hundreds never exceeds 2;
  - the ones/tens nibbles never exceed 9;
  - the add-3 is 4-bit with no carry into the neighbouring nibble.

Display scanner (free-running, independent of the FSM):

- The prescaler counts 0..`SCAN_DIV`-1. On wrap, the digit index advances ones → tens → hundreds → ones.
- `dig_en` = one-hot of the index.
- `seg` = 7-segment decode of the selected `bcd` nibble. Both are combinational from registered state.
- Decode values:
  - 0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F, 4 = 0x66;
  - 5 = 0x6D, 6 = 0x7D, 7 = 0x07, 8 = 0x7F, 9 = 0x6F;
  - nibble >9 = 0x00.
- Blanking when `blank_zeros`=1:
  - hundreds is blank if hundreds==0;
  - tens is blank if hundreds==0 and tens==0;
  - ones is never blank.
  - Blank means `seg`=0x00; `dig_en` still cycles.
- `COMMON_ANODE`=1 inverts `seg` and `dig_en` after decode and blanking.
- The displayed value changes on the same edge that `bcd` loads. No other synchronisation is applied.

## Timing

- Reset (`rst_n`=0 at an edge) puts the block in this state on the next cycle:
  - state IDLE, `ready`=1, `bcd_valid`=0;
  - `bcd`=0x000, prescaler 0, index ones;
  - `dig_en`=001 and `seg`=0x3F (both inverted if `COMMON_ANODE`).
- Reset applies in any state, including mid-CONV. The partial result is discarded and no `bcd_valid` pulse is produced.
- Latency for a transfer accepted at edge N:
  - CONV occupies edges N+1..N+8;
  - `bcd` is loaded at edge N+8;
  - `bcd_valid` is high during the cycle between edges N+8 and N+9;
  - `ready` is low for 9 cycles and returns high after edge N+9.
- The earliest next accept is edge N+10. Peak throughput is one conversion per 10 cycles.
- Scanner: each digit is selected for exactly `SCAN_DIV` cycles. With `SCAN_DIV`=1 the index advances every cycle.
- Reset restarts the scan at the ones digit.

## Test plan

- Reset: hold `rst_n`=0 for 1 edge → `ready`=1, `bcd`=0x000, `bcd_valid`=0, `dig_en`=001, `seg`=0x3F.
- Max value: offer 255 at edge N → `ready` low for 9 cycles, `bcd_valid` high only in the cycle after edge N+8, `bcd`=0x255.
- Exhaustive sweep 0..255 against a reference model. Corner spot checks: 0→0x000, 9→0x009, 10→0x010, 99→0x099, 100→0x100, 199→0x199.
- Back-to-back with `valid` held high: offer 37, then change `value` to 200 during CONV → first result 0x037, second accept at edge N+10, second result 0x200.
- Scan with `SCAN_DIV`=4 and `bcd`=0x007:
  - `blank_zeros`=1 → `dig_en` goes 001, 010, 100, 4 cycles each; `seg`=0x07 on ones and 0x00 on tens/hundreds;
  - `blank_zeros`=0 → `seg`=0x3F on tens/hundreds.
- Reset mid-conversion: assert `rst_n`=0 at edge N+4 → next cycle `ready`=1, `bcd`=0x000, and no `bcd_valid` pulse at N+8/N+9.
